sram_arb: RTL and testbench

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_arb_pick.sv | 31 +++
 rtl/sram_arb.sv | 139 +++++++++++++
 tb/tb_sram_arb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, wait-counter width, requester ids.
package sram_arb_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant decision between CPU and debug master plus the last-granted flag.
// Define SRAM_ARB_RR_EN for round-robin tie breaking; default is fixed debug priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    nreset,
  input  logic    cpu_req,
  input  logic    dbg_req,
  input  logic    take,
  output req_id_t pick_id,
  output req_id_t last_id
);

  always_comb begin
    pick_id = (cpu_req && !dbg_req) ? REQ_CPU : REQ_DBG;
`ifdef SRAM_ARB_RR_EN
    if (cpu_req && dbg_req)
      pick_id = (last_id == REQ_CPU) ? REQ_DBG : REQ_CPU;
`endif
  end

  // Also names the owner of the transaction in flight, since it only changes at grant.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      last_id <= REQ_CPU;
    else if (take)
      last_id <= pick_id;
  end

endmodule

// File: rtl/sram_arb.sv
// Two-master (CPU / debug UART) arbiter and access sequencer for an asynchronous 16-bit SRAM.
// Arbitration policy selected by macro SRAM_ARB_RR_EN (see sram_arb_pick).
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r,
  input  logic [1:0]  cpu_w,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ready,
  input  logic [15:0] dbg_addr,
  input  logic        dbg_r,
  input  logic [1:0]  dbg_w,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_ready,
  output logic [15:0] rdata,
  output logic        gnt_dbg,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_wr;
  logic             cpu_req, dbg_req, take;
  req_id_t          pick_id, last_id;
  logic [14:0]      sel_word;
  logic [15:0]      sel_wdata;
  logic [1:0]       sel_w;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = cpu_addr[0] ^ dbg_addr[0];

  // A requester still holding its request during its own ready cycle is not re-granted.
  assign cpu_req = ((|cpu_w) | cpu_r) & ~cpu_ready;
  assign dbg_req = ((|dbg_w) | dbg_r) & ~dbg_ready;
  assign take    = (state == ST_IDLE) && (cpu_req || dbg_req);

  sram_arb_pick u_pick (
    .clk     (clk),
    .nreset  (nreset),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .take    (take),
    .pick_id (pick_id),
    .last_id (last_id)
  );

  always_comb begin
    sel_word  = cpu_addr[15:1];
    sel_wdata = cpu_wdata;
    sel_w     = cpu_w;
    if (pick_id == REQ_DBG) begin
      sel_word  = dbg_addr[15:1];
      sel_wdata = dbg_wdata;
      sel_w     = dbg_w;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      is_wr      <= 1'b0;
      cpu_ready  <= 1'b0;
      dbg_ready  <= 1'b0;
      gnt_dbg    <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      cpu_ready <= 1'b0;
      dbg_ready <= 1'b0;
      case (state)
        ST_IDLE: if (take) begin
          state     <= ST_SETUP;
          gnt_dbg   <= (pick_id == REQ_DBG);
          sram_addr <= {3'b000, sel_word};
          sram_dq_o <= sel_wdata;
          is_wr     <= |sel_w;
          sram_ce_n <= 1'b0;
          if (|sel_w) begin
            sram_dq_oe <= 1'b1;
            sram_ub_n  <= ~sel_w[1];
            sram_lb_n  <= ~sel_w[0];
          end else begin
            sram_oe_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
          cnt   <= CNT_W'(WAIT);
          if (is_wr) sram_we_n <= 1'b0;
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            state     <= ST_DONE;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!is_wr) rdata <= sram_dq_i;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          sram_ce_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
          sram_lb_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          gnt_dbg    <= 1'b0;
          if (last_id == REQ_DBG) dbg_ready <= 1'b1;
          else                    cpu_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed self-checking bench for sram_arb (WAIT=3 instance plus a WAIT=0 instance).
module tb_sram_arb;

  logic        clk = 1'b0;
  logic        nreset;
  logic [15:0] cpu_addr, dbg_addr, cpu_wdata, dbg_wdata, sram_dq_i;
  logic        cpu_r, dbg_r;
  logic [1:0]  cpu_w, dbg_w;
  logic        cpu_ready, dbg_ready, gnt_dbg;
  logic [15:0] rdata, sram_dq_o;
  logic [17:0] sram_addr;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] cpu_addr0, sram_dq_i0, rdata0, sram_dq_o0;
  logic        cpu_r0, cpu_ready0, dbg_ready0, gnt_dbg0;
  logic [17:0] sram_addr0;
  logic        sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_ub_n0, sram_lb_n0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_arb #(.WAIT(3)) u_dut (
    .clk(clk), .nreset(nreset),
    .cpu_addr(cpu_addr), .cpu_r(cpu_r), .cpu_w(cpu_w), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .dbg_addr(dbg_addr), .dbg_r(dbg_r), .dbg_w(dbg_w), .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
    .rdata(rdata), .gnt_dbg(gnt_dbg), .sram_addr(sram_addr),
    .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_arb #(.WAIT(0)) u_dut0 (
    .clk(clk), .nreset(nreset),
    .cpu_addr(cpu_addr0), .cpu_r(cpu_r0), .cpu_w(2'b00), .cpu_wdata(16'h0000), .cpu_ready(cpu_ready0),
    .dbg_addr(16'h0000), .dbg_r(1'b0), .dbg_w(2'b00), .dbg_wdata(16'h0000), .dbg_ready(dbg_ready0),
    .rdata(rdata0), .gnt_dbg(gnt_dbg0), .sram_addr(sram_addr0),
    .sram_dq_i(sram_dq_i0), .sram_dq_o(sram_dq_o0), .sram_dq_oe(sram_dq_oe0),
    .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0),
    .sram_ub_n(sram_ub_n0), .sram_lb_n(sram_lb_n0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one transaction of u_dut until a ready pulse (bounded at 20 edges).
  task automatic watch(output int edges, output int ce_c, output int oe_c, output int we_c,
                       output int dqoe_c, output logic ce1, output logic gnt1,
                       output logic lb, output logic ub, output logic [15:0] dqo,
                       output int cpu_rc, output int dbg_rc);
    edges = 0; ce_c = 0; oe_c = 0; we_c = 0; dqoe_c = 0; cpu_rc = 0; dbg_rc = 0;
    ce1 = 1'b1; gnt1 = 1'b0; lb = 1'b1; ub = 1'b1; dqo = '0;
    while (edges < 20) begin
      tick();
      edges++;
      if (edges == 1) begin ce1 = sram_ce_n; gnt1 = gnt_dbg; end
      if (!sram_ce_n) ce_c++;
      if (!sram_oe_n) oe_c++;
      if (!sram_we_n) begin we_c++; lb = sram_lb_n; ub = sram_ub_n; end
      if (sram_dq_oe) begin dqoe_c++; dqo = sram_dq_o; end
      if (cpu_ready) cpu_rc++;
      if (dbg_ready) dbg_rc++;
      if (cpu_ready || dbg_ready) break;
    end
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  int edges, ce_c, oe_c, we_c, dqoe_c, cpu_rc, dbg_rc;
  logic ce1, gnt1, lb, ub;
  logic [15:0] dqo;
  logic [3:0] exp_pat;

  initial begin
    nreset = 1'b0;
    cpu_addr = '0; cpu_r = 0; cpu_w = '0; cpu_wdata = '0;
    dbg_addr = '0; dbg_r = 0; dbg_w = '0; dbg_wdata = '0;
    sram_dq_i = 16'hBEEF;
    cpu_addr0 = '0; cpu_r0 = 0; sram_dq_i0 = 16'hA5A5;

    // Reset state
    #12;
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_strobes", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 4'hF);
    check("rst_outs", {cpu_ready, dbg_ready, gnt_dbg, sram_dq_oe}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", sram_addr, 0);
    tick();
    nreset = 1'b1;
    tick();

    // CPU read, WAIT=3
    cpu_addr = 16'h4002; cpu_r = 1;
    tick();
    check("rd_sram_addr", sram_addr, 18'h02001);
    check("rd_ce_setup", sram_ce_n, 0);
    watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
    cpu_r = 0;
    check("rd_latency", edges + 1, 7);
    check("rd_rdata", rdata, 16'hBEEF);
    check("rd_oe_cycles", oe_c, 4);
    check("rd_ready_who", {cpu_rc[1:0], dbg_rc[1:0]}, 4'b0100);
    tick();
    check("rd_ready_width", {cpu_ready, dbg_ready}, 0);
    check("rd_rdata_hold", rdata, 16'hBEEF);

    // Debug low-byte write
    dbg_addr = 16'h0010; dbg_w = 2'b01; dbg_wdata = 16'h1234;
    watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
    dbg_w = 2'b00;
    check("wr_latency", edges, 7);
    check("wr_we_cycles", we_c, 4);
    check("wr_lanes", {ub, lb}, 2'b10);
    check("wr_dqoe_cycles", dqoe_c, 6);
    check("wr_ce_cycles", ce_c, 6);
    check("wr_dq_o", dqo, 16'h1234);
    check("wr_gnt", gnt1, 1);
    check("wr_ready_who", {cpu_rc[1:0], dbg_rc[1:0]}, 4'b0001);
    check("wr_addr", sram_addr, 18'h00008);
    tick();
    check("wr_ready_width", {cpu_ready, dbg_ready}, 0);

    // Simultaneous requests, loser keeps requesting
    do_reset();
    cpu_addr = 16'h0100; cpu_r = 1;
    dbg_addr = 16'h0200; dbg_r = 1;
    watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
    dbg_r = 0;
    check("tie1_gnt", gnt1, 1);
    check("tie1_who", {cpu_rc[1:0], dbg_rc[1:0]}, 4'b0001);
    watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
    cpu_r = 0;
    check("tie2_one_idle", ce1, 0);
    check("tie2_gnt", gnt1, 0);
    check("tie2_latency", edges, 7);
    check("tie2_who", {cpu_rc[1:0], dbg_rc[1:0]}, 4'b0100);
    tick();

    // Four tied rounds, loser withdraws after each
`ifdef SRAM_ARB_RR_EN
    exp_pat = 4'b0101;
`else
    exp_pat = 4'b1111;
`endif
    for (int unsigned r = 0; r < 4; r++) begin
      cpu_r = 1; dbg_r = 1;
      watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
      cpu_r = 0; dbg_r = 0;
      check($sformatf("round%0d_dbg_won", r), dbg_rc, {31'd0, exp_pat[r]});
      check($sformatf("round%0d_gnt", r), gnt1, exp_pat[r]);
      tick();
      tick();
    end

    // Reset during ACCESS of a CPU write aborts it
    cpu_addr = 16'h0020; cpu_w = 2'b11; cpu_wdata = 16'h5555;
    tick(); tick(); tick();
    check("abort_we_active", sram_we_n, 0);
    #2 nreset = 1'b0;
    #1;
    check("abort_inactive", {sram_we_n, sram_ce_n, sram_dq_oe}, 3'b110);
    cpu_w = 2'b00;
    tick();
    check("abort_no_ready", {cpu_ready, dbg_ready}, 0);
    nreset = 1'b1;
    cpu_rc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cpu_ready || dbg_ready) cpu_rc++;
    end
    check("abort_no_late_ready", cpu_rc, 0);
    cpu_w = 2'b11;
    watch(edges, ce_c, oe_c, we_c, dqoe_c, ce1, gnt1, lb, ub, dqo, cpu_rc, dbg_rc);
    cpu_w = 2'b00;
    check("reissue_latency", edges, 7);
    check("reissue_we_cycles", we_c, 4);
    check("reissue_lanes", {ub, lb}, 2'b00);
    check("reissue_ready", cpu_rc, 1);

    // WAIT=0 read on the second instance
    cpu_addr0 = 16'h0004; cpu_r0 = 1;
    edges = 0; oe_c = 0;
    while (edges < 10) begin
      tick();
      edges++;
      if (!sram_oe_n0) oe_c++;
      if (cpu_ready0) break;
    end
    cpu_r0 = 0;
    check("w0_latency", edges - 1, 3);
    check("w0_oe_cycles", oe_c, 2);
    check("w0_rdata", rdata0, 16'hA5A5);
    check("w0_addr", sram_addr0, 18'h00002);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
